dlf_phase_detector: RTL and testbench

Reference-side front end of the digital PLL. Integrates a fixed reference frequency word and a loop-controlled DCO frequency word in two phase accumulators. Each decimation window it emits an 8-bit signed phase error to Digital_Loop_Filter's `master_in`, and it consumes the filter's 8-bit control word (`slave_out`) to steer the DCO. It also drives a DCO output tick and a lock indicator.

---
 rtl/dlf_phase_detector_if.sv | 38 +++
 rtl/dlf_phase_detector.sv | 171 +++++++++++++++++
 tb/tb_dlf_phase_detector.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dlf_phase_detector_if.sv
// -----------------------------------------------------------------------------
// dlf_phase_detector_if
//   Bundle between the PLL phase detector and the digital loop filter, plus
//   the detector's status outputs.
//
//   dlf_ctrl   [7:0]  signed control word from the loop filter (slave_out)
//   phase_err  [7:0]  signed phase error to the loop filter (master_in)
//   err_valid         one-cycle strobe, phase_err updated this cycle
//   dco_tick          one-cycle pulse on each DCO accumulator wrap
//   locked            lock indicator
//
//   master: the phase detector.  slave: the loop filter / observer side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface dlf_phase_detector_if;
  logic [7:0] dlf_ctrl;
  logic [7:0] phase_err;
  logic       err_valid;
  logic       dco_tick;
  logic       locked;

  modport master (
    input  dlf_ctrl,
    output phase_err,
    output err_valid,
    output dco_tick,
    output locked
  );

  modport slave (
    output dlf_ctrl,
    input  phase_err,
    input  err_valid,
    input  dco_tick,
    input  locked
  );
endinterface

// File: rtl/dlf_phase_detector.sv
// -----------------------------------------------------------------------------
// dlf_phase_detector
//   Reference-side front end of the digital PLL.  A reference phase
//   accumulator advances by REF_FCW each cycle; a DCO phase accumulator
//   advances by a frequency word steered by the loop filter's control word.
//   Once per UPDATE_DIV-cycle window the top 8 bits of the phase difference
//   are presented to the loop filter.  A small FSM watches the error and
//   declares lock after LOCK_CNT consecutive in-window samples.
//
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   bus.dlf_ctrl     in : signed control word (sampled at mid-window only)
//   bus.phase_err    out: signed phase error, holds between strobes
//   bus.err_valid    out: one-cycle strobe when phase_err is updated
//   bus.dco_tick     out: one-cycle pulse per DCO accumulator wrap
//   bus.locked       out: high while the lock FSM is in LOCKED
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dlf_phase_detector #(
  parameter int                 PHASE_W    = 16,
  parameter logic [PHASE_W-1:0] REF_FCW    = 16'h1000,
  parameter logic [PHASE_W-1:0] CENTER_FCW = 16'h1000,
  parameter int                 GAIN_SHIFT = 4,
  parameter int                 UPDATE_DIV = 8,
  parameter int                 LOCK_THR   = 4,
  parameter int                 LOCK_CNT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  dlf_phase_detector_if.master   bus
);

  localparam int DIV_W = (UPDATE_DIV > 2) ? $clog2(UPDATE_DIV) : 1;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(UPDATE_DIV / 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LOCK_CNT);
  localparam logic [7:0]       THR_MAG  = 8'(LOCK_THR);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] ref_acc;
  logic [PHASE_W-1:0] dco_acc;
  logic [PHASE_W-1:0] fcw_reg;
  logic [DIV_W-1:0]   div_cnt;
  logic [7:0]         phase_err_q;
  logic               err_valid_q;
  logic               dco_tick_q;
  logic               locked_q;

  lock_state_t        state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

  // Carry-out of the DCO addition is the wrap indication.
  logic [PHASE_W:0]   dco_sum;
  logic [PHASE_W-1:0] phase_diff;
  logic [PHASE_W-1:0] ctrl_scaled;
  logic [7:0]         err_mag;
  logic               in_win;

  assign dco_sum     = {1'b0, dco_acc} + {1'b0, fcw_reg};
  assign phase_diff  = ref_acc - dco_acc;
  assign ctrl_scaled = {{(PHASE_W-8){bus.dlf_ctrl[7]}}, bus.dlf_ctrl} << GAIN_SHIFT;

  // Two's-complement magnitude read as unsigned: 0x80 stays 0x80 (= 128),
  // so the most negative error can never look small.
  assign err_mag = phase_err_q[7] ? (8'd0 - phase_err_q) : phase_err_q;
  assign in_win  = (err_mag <= THR_MAG);

  // NOTE: async reset in the sensitivity list, and every state update uses
  // non-blocking assignment so all flops see the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_acc     <= '0;
      dco_acc     <= '0;
      fcw_reg     <= CENTER_FCW;
      div_cnt     <= '0;
      phase_err_q <= '0;
      err_valid_q <= 1'b0;
      dco_tick_q  <= 1'b0;
    end else begin
      ref_acc    <= ref_acc + REF_FCW;
      dco_acc    <= dco_sum[PHASE_W-1:0];
      dco_tick_q <= dco_sum[PHASE_W];
      div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);

      // Mid-window load gives the loop filter half a window to settle.
      if (div_cnt == DIV_LOAD) begin
        fcw_reg <= CENTER_FCW + ctrl_scaled;
      end

      err_valid_q <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        phase_err_q <= phase_diff[PHASE_W-1 -: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM: only advances on strobe cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACQ;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (state_d == LOCKED);
    end
  end

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;

    if (err_valid_q) begin
      unique case (state_q)
        ACQ: begin
          if (in_win) begin
            state_d    = TRACK;
            lock_cnt_d = CNT_W'(1);
          end else begin
            lock_cnt_d = '0;
          end
        end

        TRACK: begin
          if (in_win) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if (lock_cnt_d == CNT_DONE) begin
              state_d = LOCKED;
            end
          end else begin
            state_d    = ACQ;
            lock_cnt_d = '0;
          end
        end

        LOCKED: begin
          if (!in_win) begin
            state_d    = ACQ;
            lock_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ACQ;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.phase_err = phase_err_q;
  assign bus.err_valid = err_valid_q;
  assign bus.dco_tick  = dco_tick_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_dlf_phase_detector.sv
// -----------------------------------------------------------------------------
// tb_dlf_phase_detector
//   Drives dlf_phase_detector with directed and random control words and
//   compares every output on every falling edge against a behavioural model
//   built from edge numbers, phase arithmetic and a run-length lock count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dlf_phase_detector;

  localparam int UPDATE_DIV = 8;
  localparam int GAIN_SHIFT = 4;
  localparam int REF_FCW    = 'h1000;
  localparam int CENTER_FCW = 'h1000;
  localparam int LOCK_THR   = 4;
  localparam int LOCK_CNT   = 16;
  localparam int MOD        = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dlf_phase_detector_if bus ();

  dlf_phase_detector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model, state described as phases and edge counts.
  // ---------------------------------------------------------------------------
  int         k;          // edges since reset release
  int         m_dco;      // DCO phase, 0..65535
  int         m_fcw;      // current DCO frequency word
  int         m_run;      // consecutive in-window strobes
  logic [7:0] m_err;
  logic       m_valid;
  logic       m_tick;
  logic       m_locked;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, k);
  endtask

  task automatic model_reset();
    k        = 0;
    m_dco    = 0;
    m_fcw    = CENTER_FCW;
    m_run    = 0;
    m_err    = 8'h00;
    m_valid  = 1'b0;
    m_tick   = 1'b0;
    m_locked = 1'b0;
  endtask

  // One rising edge: everything computed from the state visible before it.
  task automatic model_edge();
    int ref_phase, diff, e, sum, new_fcw;
    ref_phase = (k * REF_FCW) % MOD;
    k++;

    if (m_valid) begin
      e = int'($signed(m_err));
      if (e < 0) e = -e;
      m_run    = (e <= LOCK_THR) ? m_run + 1 : 0;
      m_locked = (m_run >= LOCK_CNT);
    end

    new_fcw = m_fcw;
    if (k % UPDATE_DIV == UPDATE_DIV / 2 + 1)
      new_fcw = (CENTER_FCW + int'($signed(bus.dlf_ctrl)) * (1 << GAIN_SHIFT) + MOD) % MOD;

    m_valid = (k % UPDATE_DIV == 0);
    if (m_valid) begin
      diff  = (ref_phase - m_dco + MOD) % MOD;
      m_err = 8'(diff / 256);
    end

    sum    = m_dco + m_fcw;
    m_tick = (sum >= MOD);
    m_dco  = sum % MOD;
    m_fcw  = new_fcw;
  endtask

  task automatic compare_all();
    check("phase_err", 16'(bus.phase_err), 16'(m_err));
    check("err_valid", 16'(bus.err_valid), 16'(m_valid));
    check("dco_tick",  16'(bus.dco_tick),  16'(m_tick));
    check("locked",    16'(bus.locked),    16'(m_locked));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int cycles, input logic [7:0] ctrl);
    bus.dlf_ctrl = ctrl;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Reset asserted dly ns after a rising edge, outputs checked before the
  // next edge, released on a falling edge.
  task automatic async_reset(input int dly);
    @(posedge clk);
    model_edge();
    #dly;
    rst = 1'b1;
    #1;
    check("async_rst_phase_err", 16'(bus.phase_err), 16'h0);
    check("async_rst_err_valid", 16'(bus.err_valid), 16'h0);
    check("async_rst_dco_tick",  16'(bus.dco_tick),  16'h0);
    check("async_rst_locked",    16'(bus.locked),    16'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.dlf_ctrl = 8'h00;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Zero control: lock on edge 129
    run(128, 8'h00);
    check("not_locked_edge128", 16'(bus.locked), 16'h0);
    step();
    check("locked_edge129", 16'(bus.locked), 16'h1);
    run(20, 8'h00);

    // Async reset while locked, then first strobe after edge 8
    async_reset(2);
    run(7, 8'h00);
    check("no_strobe_edge7", 16'(bus.err_valid), 16'h0);
    step();
    check("first_strobe_edge8", 16'(bus.err_valid), 16'h1);
    run(140, 8'h00);
    check("relocked_after_reset", 16'(bus.locked), 16'h1);

    // Threshold sweep: error walks -1 LSB per window through -4 / -5
    run(120, 8'h02);
    run(240, 8'hFE);
    run(120, 8'h02);

    // Relock from a clean phase, then lose lock with a large step
    async_reset(3);
    run(150, 8'h00);
    run(100, 8'h40);
    run(200, 8'h00);

    // Frequency offset: error sweeps down through 0x80 -> 0x7F
    async_reset(1);
    run(4300, 8'h01);

    // Extreme control words
    run(120, 8'h80);
    run(120, 8'h7F);

    // Random control, occasional random async reset
    for (int blk = 0; blk < 60; blk++) begin
      logic [7:0] c;
      if ($urandom_range(0, 9) == 0) async_reset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 0) c = 8'($signed(int'($urandom_range(0, 8)) - 4));
      else                           c = 8'($urandom);
      run(int'($urandom_range(8, 64)), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
